// File: rtl/pipe_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_add_pkg
//  Description : Shared constants, slice-width helper and stage record for the
//                pipelined adder family.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_add_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // Bits added per pipeline stage.
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Contents of one pipeline register in the default configuration: the
  // beat's valid bit, the carry leaving the slice just added, the sum bits
  // resolved so far and the operand bits still to be consumed downstream.
  // The adder declares a width-matched copy of this layout for its own
  // WIDTH parameter.
  typedef struct packed {
    logic                     valid;
    logic                     carry;
    logic [DEFAULT_WIDTH-1:0] sum;
    logic [DEFAULT_WIDTH-1:0] a;
    logic [DEFAULT_WIDTH-1:0] b;
  } pipe_add_stage_t;

endpackage
`default_nettype wire

// File: rtl/pipe_add_slice.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_add_slice
//  Description : W-bit combinational ripple slice, {cout,sum} = a + b + cin.
//                One instance per pipeline stage of pipelined_adder.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_add_slice
  import pipe_add_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  // Widen by one bit so the carry out of the slice falls into cout_o.
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder
//  Description : WIDTH-bit adder with carry-in/carry-out, split into STAGES
//                register stages of WIDTH/STAGES bits each, with valid/ready
//                flow control on input and output. The last stage register
//                drives the outputs directly.
//                Build option PIPE_ADD_OVF_EN adds the out_ovf signed-overflow
//                output, pipelined alongside out_cout.
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_adder
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  // Width-matched stage record (same layout as pipe_add_stage_t).
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  // Reject configurations that cannot be sliced evenly.
  if ((WIDTH < 1) || (STAGES < 1)) begin : g_bad_range
    $fatal(1, "pipelined_adder: WIDTH and STAGES must both be >= 1");
  end else if ((WIDTH % STAGES) != 0) begin : g_bad_split
    $fatal(1, "pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  stage_t           w_prev      [STAGES];  // record entering each stage
  stage_t           stage_d     [STAGES];
  stage_t           stage_q     [STAGES];
  logic [CHUNK-1:0] w_slice_sum [STAGES];
  logic             w_slice_cout[STAGES];
  logic             w_advance;

  // One global enable: the whole pipe moves only when the output register
  // is empty or being drained this cycle.
  assign w_advance = ~stage_q[STAGES-1].valid | out_ready;
  assign in_ready  = w_advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // The input port acts as stage -1; in_cin rides in the carry field.
      assign w_prev[k] = '{valid: in_valid, carry: in_cin, sum: {WIDTH{1'b0}},
                           a: in_a, b: in_b};
    end else begin : g_link
      assign w_prev[k] = stage_q[k-1];
    end

    pipe_add_slice #(
      .W (CHUNK)
    ) u_slice (
      .a_i    (w_prev[k].a[k*CHUNK +: CHUNK]),
      .b_i    (w_prev[k].b[k*CHUNK +: CHUNK]),
      .cin_i  (w_prev[k].carry),
      .sum_o  (w_slice_sum[k]),
      .cout_o (w_slice_cout[k])
    );
  end

  // Each stage forwards its input record with slice k of the sum filled in
  // and the slice carry replacing the incoming one.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k]                        = w_prev[k];
      stage_d[k].sum[k*CHUNK +: CHUNK]  = w_slice_sum[k];
      stage_d[k].carry                  = w_slice_cout[k];
    end
  end

  // Stage registers: flush on reset, shift together on advance, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else if (w_advance) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign out_sum   = stage_q[STAGES-1].sum;
  assign out_cout  = stage_q[STAGES-1].carry;

  // The final stage keeps operand copies that nothing downstream reads.
  logic w_unused;
  assign w_unused = ^{stage_q[STAGES-1].a, stage_q[STAGES-1].b};

`ifdef PIPE_ADD_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB is recovered from the MSB sum bit: c = a ^ b ^ s.
  assign ovf_d = w_prev[STAGES-1].a[WIDTH-1] ^ w_prev[STAGES-1].b[WIDTH-1]
               ^ w_slice_sum[STAGES-1][CHUNK-1] ^ w_slice_cout[STAGES-1];

  // Overflow flag register, timed and reset exactly like the carry out.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (w_advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_adder
//  Description : Self-checking bench for pipelined_adder: directed table of
//                vectors on a 16/4 instance, backpressure and reset sequences,
//                and random traffic on 8/1 and 32/8 instances, all scored
//                against queued expected results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_adder;

  localparam int W0 = 16, S0 = 4;
  localparam int W1 = 8,  S1 = 1;
  localparam int W2 = 32, S2 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [63:0] got,
                              input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  function automatic logic ovf_of(input logic am, input logic bm, input logic sm);
    return (am == bm) && (sm != am);
  endfunction

  typedef struct {
    logic [32:0] res;
    logic        ovf;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  // ---------------- DUT 0 : 16 bits, 4 stages ----------------
  logic          d0_iv, d0_irdy, d0_ov, d0_ordy, d0_cin, d0_cout, d0_ovf;
  logic [W0-1:0] d0_a, d0_b, d0_sum;
  logic [W0:0]   e0_res;
  logic          e0_ovf;
  bit            lat0 = 1'b0;
  exp_t          q0[$];
  exp_t          m0;

  pipelined_adder #(.WIDTH(W0), .STAGES(S0)) u_dut (
    .clk (clk), .rst (rst),
    .in_valid (d0_iv), .in_ready (d0_irdy),
    .in_a (d0_a), .in_b (d0_b), .in_cin (d0_cin),
    .out_valid (d0_ov), .out_ready (d0_ordy),
    .out_sum (d0_sum), .out_cout (d0_cout)
`ifdef PIPE_ADD_OVF_EN
    , .out_ovf (d0_ovf)
`endif
  );
`ifndef PIPE_ADD_OVF_EN
  assign d0_ovf = 1'b0;
`endif

  // ---------------- DUT 1 : 8 bits, 1 stage ----------------
  logic          d1_iv, d1_irdy, d1_ov, d1_ordy, d1_cin, d1_cout, d1_ovf;
  logic [W1-1:0] d1_a, d1_b, d1_sum;
  logic [W1:0]   e1_res;
  logic          e1_ovf;
  bit            lat1 = 1'b0;
  exp_t          q1[$];
  exp_t          m1;

  pipelined_adder #(.WIDTH(W1), .STAGES(S1)) u_dut8 (
    .clk (clk), .rst (rst),
    .in_valid (d1_iv), .in_ready (d1_irdy),
    .in_a (d1_a), .in_b (d1_b), .in_cin (d1_cin),
    .out_valid (d1_ov), .out_ready (d1_ordy),
    .out_sum (d1_sum), .out_cout (d1_cout)
`ifdef PIPE_ADD_OVF_EN
    , .out_ovf (d1_ovf)
`endif
  );
`ifndef PIPE_ADD_OVF_EN
  assign d1_ovf = 1'b0;
`endif

  // ---------------- DUT 2 : 32 bits, 8 stages ----------------
  logic          d2_iv, d2_irdy, d2_ov, d2_ordy, d2_cin, d2_cout, d2_ovf;
  logic [W2-1:0] d2_a, d2_b, d2_sum;
  logic [W2:0]   e2_res;
  logic          e2_ovf;
  bit            lat2 = 1'b0;
  exp_t          q2[$];
  exp_t          m2;

  pipelined_adder #(.WIDTH(W2), .STAGES(S2)) u_dut32 (
    .clk (clk), .rst (rst),
    .in_valid (d2_iv), .in_ready (d2_irdy),
    .in_a (d2_a), .in_b (d2_b), .in_cin (d2_cin),
    .out_valid (d2_ov), .out_ready (d2_ordy),
    .out_sum (d2_sum), .out_cout (d2_cout)
`ifdef PIPE_ADD_OVF_EN
    , .out_ovf (d2_ovf)
`endif
  );
`ifndef PIPE_ADD_OVF_EN
  assign d2_ovf = 1'b0;
`endif

  // Scoreboards: pop/compare on output transfer, hold check on stall,
  // push the pending expected value on input transfer. Reset flushes.
  always @(negedge clk) begin
    if (rst) q0.delete();
    else begin
      if (d0_ov && d0_ordy) begin
        if (q0.size() == 0) fail_now("m16_unexpected_beat");
        else begin
          m0 = q0.pop_front();
          chk("m16_cout_sum", 64'({d0_cout, d0_sum}), 64'(m0.res));
`ifdef PIPE_ADD_OVF_EN
          chk("m16_ovf", 64'(d0_ovf), 64'(m0.ovf));
`endif
          if (lat0) chk("m16_latency", 64'(cyc - m0.cyc), 64'(S0));
        end
      end else if (d0_ov && q0.size() != 0) begin
        chk("m16_hold", 64'({d0_cout, d0_sum}), 64'(q0[0].res));
      end
      if (d0_iv && d0_irdy) q0.push_back('{res: 33'(e0_res), ovf: e0_ovf, cyc: cyc});
    end
  end

  always @(negedge clk) begin
    if (rst) q1.delete();
    else begin
      if (d1_ov && d1_ordy) begin
        if (q1.size() == 0) fail_now("w8_unexpected_beat");
        else begin
          m1 = q1.pop_front();
          chk("w8_cout_sum", 64'({d1_cout, d1_sum}), 64'(m1.res));
`ifdef PIPE_ADD_OVF_EN
          chk("w8_ovf", 64'(d1_ovf), 64'(m1.ovf));
`endif
          if (lat1) chk("w8_latency", 64'(cyc - m1.cyc), 64'(S1));
        end
      end else if (d1_ov && q1.size() != 0) begin
        chk("w8_hold", 64'({d1_cout, d1_sum}), 64'(q1[0].res));
      end
      if (d1_iv && d1_irdy) q1.push_back('{res: 33'(e1_res), ovf: e1_ovf, cyc: cyc});
    end
  end

  always @(negedge clk) begin
    if (rst) q2.delete();
    else begin
      if (d2_ov && d2_ordy) begin
        if (q2.size() == 0) fail_now("w32_unexpected_beat");
        else begin
          m2 = q2.pop_front();
          chk("w32_cout_sum", 64'({d2_cout, d2_sum}), 64'(m2.res));
`ifdef PIPE_ADD_OVF_EN
          chk("w32_ovf", 64'(d2_ovf), 64'(m2.ovf));
`endif
          if (lat2) chk("w32_latency", 64'(cyc - m2.cyc), 64'(S2));
        end
      end else if (d2_ov && q2.size() != 0) begin
        chk("w32_hold", 64'({d2_cout, d2_sum}), 64'(q2[0].res));
      end
      if (d2_iv && d2_irdy) q2.push_back('{res: 33'(e2_res), ovf: e2_ovf, cyc: cyc});
    end
  end

  function automatic int qsize(input int which);
    case (which)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Offer one beat to DUT 0 and hold it until accepted (bounded).
  task automatic drive0(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [16:0] res, input logic ovf, output int tries);
    bit done = 1'b0;
    tries = 0;
    d0_a = a; d0_b = b; d0_cin = cin; e0_res = res; e0_ovf = ovf; d0_iv = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      tries++;
      done = d0_irdy;
      @(posedge clk); #1;
    end
    if (!done) fail_now("m16_accept_timeout");
    d0_iv = 1'b0;
  endtask

  task automatic drain(input int which);
    for (int n = 0; n < 400 && qsize(which) != 0; n++) begin
      @(posedge clk); #1;
    end
    chk($sformatf("drain%0d_queue_empty", which), 64'(qsize(which)), 64'd0);
  endtask

  // Random traffic into the 8-bit instance; beats held until accepted.
  task automatic run8(input int nbeats, input bit rnd_ready);
    int  sent = 0;
    int  guard = 0;
    bit  acc;
    d1_iv = 1'b0;
    while (sent < nbeats && guard < 60000) begin
      if (!d1_iv && $urandom_range(0, 3) != 0) begin
        d1_a = 8'($urandom); d1_b = 8'($urandom); d1_cin = 1'($urandom);
        e1_res = {1'b0, d1_a} + {1'b0, d1_b} + 9'(d1_cin);
        e1_ovf = ovf_of(d1_a[7], d1_b[7], e1_res[7]);
        d1_iv = 1'b1;
      end
      d1_ordy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = d1_iv && d1_irdy;
      @(posedge clk); #1;
      if (acc) begin sent++; d1_iv = 1'b0; end
      guard++;
    end
    if (sent < nbeats) fail_now("w8_random_timeout");
    d1_iv = 1'b0; d1_ordy = 1'b1;
  endtask

  task automatic run32(input int nbeats, input bit rnd_ready);
    int  sent = 0;
    int  guard = 0;
    bit  acc;
    d2_iv = 1'b0;
    while (sent < nbeats && guard < 60000) begin
      if (!d2_iv && $urandom_range(0, 3) != 0) begin
        d2_a = $urandom; d2_b = $urandom; d2_cin = 1'($urandom);
        e2_res = {1'b0, d2_a} + {1'b0, d2_b} + 33'(d2_cin);
        e2_ovf = ovf_of(d2_a[31], d2_b[31], e2_res[31]);
        d2_iv = 1'b1;
      end
      d2_ordy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = d2_iv && d2_irdy;
      @(posedge clk); #1;
      if (acc) begin sent++; d2_iv = 1'b0; end
      guard++;
    end
    if (sent < nbeats) fail_now("w32_random_timeout");
    d2_iv = 1'b0; d2_ordy = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          tries;
  logic [15:0] fa, fb;
  logic        fc;
  logic [16:0] fr;

  initial begin
    vecs[0] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b0};
    vecs[1] = '{a: 16'h0001, b: 16'h0002, cin: 1'b0, sum: 16'h0003, cout: 1'b0, ovf: 1'b0};
    vecs[2] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, sum: 16'h5556, cout: 1'b0, ovf: 1'b0};
    vecs[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sum: 16'h8000, cout: 1'b0, ovf: 1'b1};
    vecs[5] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1, ovf: 1'b0};
    vecs[6] = '{a: 16'hAAAA, b: 16'h5555, cin: 1'b0, sum: 16'hFFFF, cout: 1'b0, ovf: 1'b0};
    vecs[7] = '{a: 16'h0000, b: 16'h0000, cin: 1'b1, sum: 16'h0001, cout: 1'b0, ovf: 1'b0};

    d0_iv = 0; d0_a = 0; d0_b = 0; d0_cin = 0; d0_ordy = 1; e0_res = 0; e0_ovf = 0;
    d1_iv = 0; d1_a = 0; d1_b = 0; d1_cin = 0; d1_ordy = 1; e1_res = 0; e1_ovf = 0;
    d2_iv = 0; d2_a = 0; d2_b = 0; d2_cin = 0; d2_ordy = 1; e2_res = 0; e2_ovf = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(d0_ov), 64'd0);
    chk("rst_out_sum", 64'(d0_sum), 64'd0);
    chk("rst_out_cout", 64'(d0_cout), 64'd0);
    chk("rst_out_ovf", 64'(d0_ovf), 64'd0);
    chk("rst_in_ready", 64'(d0_irdy), 64'd1);
    chk("rst_w8_out_valid", 64'(d1_ov), 64'd0);
    chk("rst_w32_out_valid", 64'(d2_ov), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single beat through a full carry ripple, exact latency
    lat0 = 1'b1;
    drive0(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0, tries);
    for (int i = 0; i < S0 - 1; i++) begin
      @(negedge clk);
      chk("t1_out_valid_early", 64'(d0_ov), 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t1_out_valid_at_latency", 64'(d0_ov), 64'd1);
    @(posedge clk); #1;
    drain(0);

    // Table of vectors, back to back at full rate
    for (int i = 0; i < 8; i++) begin
      drive0(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum},
             vecs[i].ovf, tries);
      chk("t2_in_ready_first_try", 64'(tries), 64'd1);
    end
    drain(0);

    // Backpressure: fill, stall 5 cycles, release
    lat0 = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          fa = 16'(i * 4951 + 32768);
          fb = 16'(i * 9320 + 77);
          fc = 1'(i & 1);
          fr = {1'b0, fa} + {1'b0, fb} + 17'(fc);
          drive0(fa, fb, fc, fr, ovf_of(fa[15], fb[15], fr[15]), tries);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        d0_ordy = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("t3_in_ready_stalled", 64'(d0_irdy), 64'd0);
          chk("t3_out_valid_stalled", 64'(d0_ov), 64'd1);
          @(posedge clk); #1;
        end
        d0_ordy = 1'b1;
      end
    join
    drain(0);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      fa = 16'(i + 1);
      fr = {1'b0, fa} + 17'h00100;
      drive0(fa, 16'h0100, 1'b0, fr, 1'b0, tries);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_out_valid_after_rst", 64'(d0_ov), 64'd0);
    chk("t4_out_sum_after_rst", 64'(d0_sum), 64'd0);
    chk("t4_out_cout_after_rst", 64'(d0_cout), 64'd0);
    chk("t4_out_ovf_after_rst", 64'(d0_ovf), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t4_flushed_beat_absent", 64'(d0_ov), 64'd0);
    end
    @(posedge clk); #1;
    lat0 = 1'b1;
    drive0(16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1, tries);
    drain(0);

    // Random traffic on the other shapes: unstalled latency, then full random
    lat1 = 1'b1; lat2 = 1'b1;
    fork
      run8(300, 1'b0);
      run32(300, 1'b0);
    join
    drain(1); drain(2);
    lat1 = 1'b0; lat2 = 1'b0;
    fork
      run8(10000, 1'b1);
      run32(10000, 1'b1);
    join
    drain(1); drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
